// File: rtl/dtcm_sram_ctrl.sv
`default_nettype none
// ==========================================================================
// dtcm_sram_ctrl : valid/ready LSU front end for a 1-cycle synchronous TCM SRAM
// Rev 1.0
// ==========================================================================
module dtcm_sram_ctrl #(
  parameter int unsigned   DP        = 512,
  parameter int unsigned   DW        = 32,
  parameter int unsigned   MW        = 4,
  parameter int unsigned   AW        = 32,
  parameter logic [AW-1:0] BASE_ADDR = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic [AW-1:0] cmd_addr_i,
  input  logic          cmd_write_i,
  input  logic [1:0]    cmd_size_i,
  input  logic [DW-1:0] cmd_wdata_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [DW-1:0] rsp_rdata_o,
  output logic          rsp_err_o,
  output logic [AW-1:0] ram_addr_o,
  output logic          ram_we_o,
  output logic [MW-1:0] ram_wem_o,
  output logic [DW-1:0] ram_din_o,
  input  logic [DW-1:0] ram_dout_i
);

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_BAD  = 2'd3;

  logic [AW-1:0] off;
  logic [AW-1:0] idx;
  logic          misalign;
  logic          out_of_range;
  logic          err;
  logic          fire;
  logic          access;

  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_read_q,  rsp_read_d;
  logic          rsp_err_q,   rsp_err_d;
  logic          rsp_cap_q,   rsp_cap_d;
  logic [DW-1:0] rsp_data_q,  rsp_data_d;
  logic [AW-1:0] addr_hold_q, addr_hold_d;

  assign off = cmd_addr_i - BASE_ADDR;
  assign idx = {2'b00, off[AW-1:2]};

  always_comb begin
    misalign = 1'b0;
    unique case (cmd_size_i)
      SZ_HALF: misalign = off[0];
      SZ_WORD: misalign = |off[1:0];
      SZ_BAD:  misalign = 1'b1;
      default: misalign = 1'b0;
    endcase
  end

  // Below-base addresses wrap in the subtraction, so they are trapped separately.
  assign out_of_range = (cmd_addr_i < BASE_ADDR) || (idx >= AW'(DP));
  assign err          = misalign | out_of_range;

  // A full stage can still accept when its current response leaves this cycle.
  assign cmd_ready_o = rst_n & (~rsp_valid_q | rsp_ready_i);
  assign fire        = cmd_valid_i & cmd_ready_o;
  assign access      = fire & ~err;

  // SRAM samples its address whenever we=0, so idle cycles replay the last one.
  assign ram_addr_o = access ? idx : addr_hold_q;
  assign ram_we_o   = access & cmd_write_i;

  always_comb begin
    ram_wem_o = '0;
    ram_din_o = cmd_wdata_i;
    unique case (cmd_size_i)
      SZ_BYTE: begin
        ram_wem_o = MW'(1) << off[1:0];
        ram_din_o = {(DW/8){cmd_wdata_i[7:0]}};
      end
      SZ_HALF: begin
        ram_wem_o = MW'(3) << off[1:0];
        ram_din_o = {(DW/16){cmd_wdata_i[15:0]}};
      end
      SZ_WORD: begin
        ram_wem_o = '1;
        ram_din_o = cmd_wdata_i;
      end
      default: begin
        ram_wem_o = '0;
        ram_din_o = cmd_wdata_i;
      end
    endcase
    if (!ram_we_o) begin
      ram_wem_o = '0;
    end
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_read_d  = rsp_read_q;
    rsp_err_d   = rsp_err_q;
    rsp_cap_d   = rsp_cap_q;
    rsp_data_d  = rsp_data_q;
    addr_hold_d = addr_hold_q;
    if (access) begin
      addr_hold_d = idx;
    end
    if (fire) begin
      rsp_valid_d = 1'b1;
      rsp_read_d  = ~cmd_write_i & ~err;
      rsp_err_d   = err;
      rsp_cap_d   = 1'b0;
    end else if (rsp_valid_q && rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end else if (rsp_valid_q && !rsp_cap_q) begin
      // SRAM output is only guaranteed for one cycle; freeze it for the stall.
      rsp_data_d = ram_dout_i;
      rsp_cap_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_read_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_cap_q   <= 1'b0;
      rsp_data_q  <= '0;
      addr_hold_q <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_read_q  <= rsp_read_d;
      rsp_err_q   <= rsp_err_d;
      rsp_cap_q   <= rsp_cap_d;
      rsp_data_q  <= rsp_data_d;
      addr_hold_q <= addr_hold_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;

  always_comb begin
    rsp_rdata_o = '0;
    if (rsp_read_q) begin
      rsp_rdata_o = rsp_cap_q ? rsp_data_q : ram_dout_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dtcm_sram_ctrl.sv
`default_nettype none
// ==========================================================================
// tb_dtcm_sram_ctrl : directed bench for dtcm_sram_ctrl with a 1-cycle SRAM model
// Rev 1.0
// ==========================================================================
module tb_dtcm_sram_ctrl;

  localparam int unsigned DP = 512;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic        cmd_write;
  logic [1:0]  cmd_size;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] ram_addr;
  logic        ram_we;
  logic [3:0]  ram_wem;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;

  int errors;
  int checks;

  logic [31:0] mem [0:DP-1];

  dtcm_sram_ctrl #(
    .DP(DP), .DW(32), .MW(4), .AW(32), .BASE_ADDR(32'h0000_0000)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready),
    .cmd_addr_i (cmd_addr),
    .cmd_write_i(cmd_write),
    .cmd_size_i (cmd_size),
    .cmd_wdata_i(cmd_wdata),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata),
    .rsp_err_o  (rsp_err),
    .ram_addr_o (ram_addr),
    .ram_we_o   (ram_we),
    .ram_wem_o  (ram_wem),
    .ram_din_o  (ram_din),
    .ram_dout_i (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous SRAM: byte-masked write, otherwise registered read of ram_addr.
  always @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_wem[b]) mem[ram_addr[8:0]][8*b +: 8] <= ram_din[8*b +: 8];
      end
    end else begin
      ram_dout <= mem[ram_addr[8:0]];
    end
  end

  task automatic drive(input logic v, input logic w, input logic [1:0] s,
                       input logic [31:0] a, input logic [31:0] d);
    cmd_valid = v;
    cmd_write = w;
    cmd_size  = s;
    cmd_addr  = a;
    cmd_wdata = d;
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    drive(1'b1, 1'b1, 2'd2, 32'h8, 32'h5555_5555);
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready got=%b exp=0", cmd_ready); end
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++;
    if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram_we got=%b exp=0", ram_we); end
    checks++;
    if (ram_addr !== 32'd0) begin errors++; $display("FAIL reset_ram_addr got=%h exp=0", ram_addr); end
    checks++;
    if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); end
    @(negedge clk);
    drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    rst_n = 1'b1;
  endtask

  task automatic test_store_load;
    @(negedge clk);
    drive(1'b1, 1'b1, 2'd2, 32'h8, 32'hDEAD_BEEF);
    #1;
    checks++;
    if (ram_we !== 1'b1 || ram_wem !== 4'hF || ram_din !== 32'hDEAD_BEEF || ram_addr !== 32'd2) begin
      errors++;
      $display("FAIL st_word_port got we=%b wem=%h din=%h addr=%h exp 1/f/deadbeef/2", ram_we, ram_wem, ram_din, ram_addr);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'd0) begin
      errors++;
      $display("FAIL st_word_rsp got v=%b e=%b d=%h exp 1/0/0", rsp_valid, rsp_err, rsp_rdata);
    end
    drive(1'b1, 1'b0, 2'd2, 32'h8, 32'h0);
    #1;
    checks++;
    if (ram_we !== 1'b0 || ram_addr !== 32'd2) begin
      errors++; $display("FAIL ld_word_port got we=%b addr=%h exp 0/2", ram_we, ram_addr);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL ld_word_rsp got v=%b e=%b d=%h exp 1/0/deadbeef", rsp_valid, rsp_err, rsp_rdata);
    end
    drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL idle_after_ld got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_byte_merge;
    @(negedge clk);
    drive(1'b1, 1'b1, 2'd2, 32'hC, 32'h1122_3344);
    @(negedge clk);
    drive(1'b1, 1'b1, 2'd0, 32'hD, 32'h0000_00A5);
    #1;
    checks++;
    if (ram_wem !== 4'b0010 || ram_din !== 32'hA5A5_A5A5 || ram_addr !== 32'd3) begin
      errors++;
      $display("FAIL st_byte_port got wem=%b din=%h addr=%h exp 0010/a5a5a5a5/3", ram_wem, ram_din, ram_addr);
    end
    @(negedge clk);
    drive(1'b1, 1'b1, 2'd1, 32'h12, 32'h0000_BEEF);
    #1;
    checks++;
    if (ram_wem !== 4'b1100 || ram_din !== 32'hBEEF_BEEF || ram_addr !== 32'd4) begin
      errors++;
      $display("FAIL st_half_port got wem=%b din=%h addr=%h exp 1100/beefbeef/4", ram_wem, ram_din, ram_addr);
    end
    @(negedge clk);
    drive(1'b1, 1'b0, 2'd2, 32'hC, 32'h0);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1122_A544) begin
      errors++; $display("FAIL byte_merge got v=%b d=%h exp 1/1122a544", rsp_valid, rsp_rdata);
    end
    drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    @(negedge clk);
  endtask

  task automatic test_errors;
    logic [31:0] ea [4];
    logic [1:0]  es [4];
    logic        ew [4];
    ea[0] = 32'h1;          es[0] = 2'd1; ew[0] = 1'b1;
    ea[1] = 32'h0;          es[1] = 2'd3; ew[1] = 1'b0;
    ea[2] = 32'(4*DP);      es[2] = 2'd2; ew[2] = 1'b0;
    ea[3] = 32'h6;          es[3] = 2'd2; ew[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'b1, ew[i], es[i], ea[i], 32'hFFFF_FFFF);
      #1;
      checks++;
      if (ram_we !== 1'b0 || ram_addr !== 32'd3) begin
        errors++; $display("FAIL err%0d_port got we=%b addr=%h exp 0/3", i, ram_we, ram_addr);
      end
      @(negedge clk);
      drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'd0) begin
        errors++;
        $display("FAIL err%0d_rsp got v=%b e=%b d=%h exp 1/1/0", i, rsp_valid, rsp_err, rsp_rdata);
      end
    end
    @(negedge clk);
    drive(1'b1, 1'b0, 2'd2, 32'(4*DP-4), 32'h0);
    #1;
    checks++;
    if (ram_addr !== 32'(DP-1)) begin errors++; $display("FAIL last_word_addr got=%h exp=%h", ram_addr, DP-1); end
    @(negedge clk);
    drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL last_word_rsp got v=%b e=%b exp 1/0", rsp_valid, rsp_err);
    end
    @(negedge clk);
  endtask

  task automatic test_stall;
    @(negedge clk);
    drive(1'b1, 1'b1, 2'd2, 32'h4, 32'hCAFE_F00D);
    @(negedge clk);
    drive(1'b1, 1'b0, 2'd2, 32'h4, 32'h0);
    @(negedge clk);
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFE_F00D) begin
        errors++; $display("FAIL stall%0d_rsp got v=%b d=%h exp 1/cafef00d", i, rsp_valid, rsp_rdata);
      end
      drive(1'b1, i[0], 2'd2, 32'h40 + 32'(i*4), 32'h7777_0000 + 32'(i));
      #1;
      checks++;
      if (cmd_ready !== 1'b0 || ram_we !== 1'b0 || ram_addr !== 32'd1) begin
        errors++;
        $display("FAIL stall%0d_port got rdy=%b we=%b addr=%h exp 0/0/1", i, cmd_ready, ram_we, ram_addr);
      end
      @(negedge clk);
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL stall_end_rsp got v=%b d=%h exp 1/cafef00d", rsp_valid, rsp_rdata);
    end
    rsp_ready = 1'b1;
    drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready got=%b exp=1", cmd_ready); end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL stall_drained got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_d [10];
    for (int i = 0; i < 10; i++) exp_d[i] = 32'h1000_0000 + 32'h0101_0101 * 32'(i);
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'd0) begin
          errors++; $display("FAIL b2b_st%0d got v=%b e=%b d=%h exp 1/0/0", i-1, rsp_valid, rsp_err, rsp_rdata);
        end
      end
      if (i < 10) drive(1'b1, 1'b1, 2'd2, 32'h40 + 32'(4*i), exp_d[i]);
      else        drive(1'b1, 1'b0, 2'd2, 32'h40, 32'h0);
    end
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== exp_d[i-1]) begin
        errors++; $display("FAIL b2b_ld%0d got v=%b d=%h exp 1/%h", i-1, rsp_valid, rsp_rdata, exp_d[i-1]);
      end
      if (i < 10) drive(1'b1, 1'b0, 2'd2, 32'h40 + 32'(4*i), 32'h0);
      else        drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    drive(1'b1, 1'b0, 2'd2, 32'h4, 32'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre got=%b exp=1", rsp_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
      errors++; $display("FAIL rmid_async got v=%b rdy=%b exp 0/0", rsp_valid, cmd_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (ram_addr !== 32'd0) begin errors++; $display("FAIL rmid_addr got=%h exp=0", ram_addr); end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rmid_no_rsp got=%b exp=0", rsp_valid); end
    rsp_ready = 1'b1;
    drive(1'b1, 1'b0, 2'd2, 32'h8, 32'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL rmid_next got v=%b d=%h exp 1/deadbeef", rsp_valid, rsp_rdata);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_store_load();
    test_byte_merge();
    test_errors();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
